// File: rtl/gsr_release_seq.sv
// gsr_release_seq: drives the global set/reset net with a stretched low pulse, then a hold-off before signalling completion
module gsr_release_seq #(
  parameter int STRETCH = 16,
  parameter int HOLDOFF = 4,
  parameter int CNT_W   = 8
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             REQ,
  input  logic             SP,
  output logic             GSRN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CNT
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLDOFF - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic req_q, gsrn_q, gsrn_d, busy_q, busy_d, done_q, done_d;
  logic rise, fin;
  assign rise = REQ & ~req_q;
  assign fin  = SP & ((state_q == S_ASSERT && cnt_q == S_LAST) || (state_q == S_HOLD && cnt_q == H_LAST));
  // state, counter and registered outputs; reset lands directly in ASSERT with the request detector pre-armed
  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      req_q   <= 1'b1;
      gsrn_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= REQ;
      gsrn_q  <= gsrn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // a new request restarts the pulse ahead of any count completion; SP gates all progress
  always_comb begin
    state_d = rise ? S_ASSERT :
              state_q == S_ASSERT ? (fin ? S_HOLD : S_ASSERT) :
              state_q == S_HOLD   ? (fin ? S_IDLE : S_HOLD) : S_IDLE;
    cnt_d   = (rise || fin || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(SP);
  end
  // outputs are decoded from the next state so they can be registered alongside it
  always_comb begin
    gsrn_d = state_d != S_ASSERT;
    busy_d = state_d != S_IDLE;
    done_d = !rise && fin && state_q == S_HOLD;
  end
  assign GSRN = gsrn_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign CNT  = cnt_q;
endmodule

// File: tb/tb_gsr_release_seq.sv
// tb_gsr_release_seq: checks default and minimum-parameter instances against a progress-count model
module tb_gsr_release_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic cd, req, sp;
  logic g0, b0, d0, g1, b1, d1;
  logic [7:0] c0, c1;
  gsr_release_seq u0 (.CK(clk), .CD(cd), .REQ(req), .SP(sp), .GSRN(g0), .BUSY(b0), .DONE(d0), .CNT(c0));
  gsr_release_seq #(.STRETCH(1), .HOLDOFF(1)) u1 (.CK(clk), .CD(cd), .REQ(req), .SP(sp), .GSRN(g1), .BUSY(b1), .DONE(d1), .CNT(c1));
  int errors = 0, checks = 0;
  int sl[2] = '{16, 1};
  int hl[2] = '{4, 1};
  // model: one progress count across the whole sequence; the first sl steps are the low pulse, the next hl the hold-off
  bit act[2], dn[2];
  int p[2];
  bit rp;
  function automatic logic [10:0] exp_of(int i);
    int c;
    c = !act[i] ? 0 : (p[i] < sl[i] ? p[i] : p[i] - sl[i]);
    return {!(act[i] && p[i] < sl[i]), act[i], dn[i], 8'(c)};
  endfunction
  function automatic logic [10:0] obs(int i);
    return i == 0 ? {g0, b0, d0, c0} : {g1, b1, d1, c1};
  endfunction
  task automatic tick;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (cd) begin
        act[i] = 1; p[i] = 0; dn[i] = 0;
      end else begin
        dn[i] = 0;
        if (req && !rp) begin
          act[i] = 1; p[i] = 0;
        end else if (act[i] && sp) begin
          p[i]++;
          if (p[i] == sl[i] + hl[i]) begin act[i] = 0; p[i] = 0; dn[i] = 1; end
        end
      end
    end
    rp = cd ? 1'b1 : req;
    #1;
  endtask
  task automatic test_reset;
    int lows, dones;
    cd = 1; req = 0; sp = 1;
    tick; tick;
    checks++;
    if ({g0, b0, d0, c0} !== 11'b010_0000_0000) begin errors++; $display("FAIL reset_state got=%b exp=%b", {g0, b0, d0, c0}, 11'b010_0000_0000); end
    cd = 0; lows = 1; dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      lows += !g0; dones += d0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL powerup inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    checks++;
    if (lows != 16) begin errors++; $display("FAIL powerup_low_len got=%0d exp=16", lows); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL powerup_done_cnt got=%0d exp=1", dones); end
  endtask
  task automatic test_request;
    int lows, dones;
    lows = 0; dones = 0;
    req = 0; sp = 1; tick;
    req = 1;
    for (int k = 0; k < 50; k++) begin
      tick;
      lows += !g0; dones += d0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL request inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    checks++;
    if (lows != 16 || dones != 1) begin errors++; $display("FAIL request_held got=lows%0d/dones%0d exp=lows16/dones1", lows, dones); end
    req = 0;
  endtask
  task automatic test_sp_gating;
    int lows, dones;
    lows = 0; dones = 0;
    req = 0; sp = 1; tick;
    req = 1; tick;
    lows += !g0;
    for (int k = 0; k < 50; k++) begin
      sp = (k % 2) == 0;
      tick;
      lows += !g0; dones += d0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL sp_toggle inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    checks++;
    if (lows != 31 || dones != 1) begin errors++; $display("FAIL sp_toggle_len got=lows%0d/dones%0d exp=lows31/dones1", lows, dones); end
    req = 0; sp = 1; tick;
    req = 1;
    for (int k = 0; k < 60; k++) begin
      sp = $urandom_range(0, 1);
      tick;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL sp_random inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    req = 0;
  endtask
  task automatic test_retrigger;
    int dones, k;
    dones = 0;
    sp = 1; req = 0; tick;
    req = 1; tick; req = 0;
    for (k = 0; k < 40 && !(g0 == 0 && c0 == 10); k++) tick;
    checks++;
    if (k == 40) begin errors++; $display("FAIL retrig_assert_wait got=timeout exp=cnt10"); end
    req = 1; tick; req = 0;
    checks++;
    if ({g0, b0, c0} !== 10'b01_0000_0000) begin errors++; $display("FAIL retrig_assert got=%b exp=%b", {g0, b0, c0}, 10'b01_0000_0000); end
    for (k = 0; k < 40 && !(g0 == 1 && b0 == 1 && c0 == 2); k++) begin
      tick;
      dones += d0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL retrig_a inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    checks++;
    if (k == 40) begin errors++; $display("FAIL retrig_hold_wait got=timeout exp=hold_cnt2"); end
    req = 1; tick; req = 0;
    checks++;
    if ({g0, d0, c0} !== 10'b0) begin errors++; $display("FAIL retrig_hold got=%b exp=%b", {g0, d0, c0}, 10'b0); end
    for (k = 0; k < 40; k++) begin
      tick;
      dones += d0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL retrig_b inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL retrig_done_cnt got=%0d exp=1", dones); end
  endtask
  task automatic test_collision;
    int lows, k;
    sp = 1; req = 0; tick;
    req = 1; tick; req = 0;
    for (k = 0; k < 40 && !(g0 == 1 && b0 == 1 && c0 == 3); k++) tick;
    checks++;
    if (k == 40) begin errors++; $display("FAIL collide_wait got=timeout exp=hold_cnt3"); end
    req = 1; tick;
    checks++;
    if ({g0, b0, d0, c0} !== 11'b010_0000_0000) begin errors++; $display("FAIL collide_hold got=%b exp=%b", {g0, b0, d0, c0}, 11'b010_0000_0000); end
    req = 0; tick; tick;
    cd = 1; req = 1; tick;
    checks++;
    if ({g0, b0, d0, c0} !== 11'b010_0000_0000) begin errors++; $display("FAIL collide_cd got=%b exp=%b", {g0, b0, d0, c0}, 11'b010_0000_0000); end
    cd = 0; lows = 1;
    for (k = 0; k < 40; k++) begin
      tick;
      lows += !g0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL collide_cd_run inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    checks++;
    if (lows != 16) begin errors++; $display("FAIL collide_cd_low_len got=%0d exp=16", lows); end
    req = 0;
  endtask
  task automatic test_min_params;
    int lows, busys, rise_k, done_k;
    lows = 0; busys = 0; rise_k = -1; done_k = -1;
    sp = 1; req = 0;
    for (int k = 0; k < 25; k++) tick;
    req = 1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      lows += !g1; busys += b1;
      if (g1 && lows == 1 && rise_k < 0) rise_k = k;
      if (d1 && done_k < 0) done_k = k;
      checks++;
      if (obs(1) !== exp_of(1)) begin errors++; $display("FAIL min_seq cyc%0d got=%h exp=%h", k, obs(1), exp_of(1)); end
    end
    checks++;
    if (lows != 1 || busys != 2) begin errors++; $display("FAIL min_len got=lows%0d/busys%0d exp=lows1/busys2", lows, busys); end
    checks++;
    if (rise_k < 0 || done_k != rise_k + 1) begin errors++; $display("FAIL min_done_timing got=rise%0d/done%0d exp=done=rise+1", rise_k, done_k); end
    req = 0;
  endtask
  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      cd  = $urandom_range(0, 99) < 2;
      req = ($urandom_range(0, 9) < 2) ? ~req : req;
      sp  = $urandom_range(0, 3) != 0;
      tick;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_of(i)) begin errors++; $display("FAIL random inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_of(i)); end
      end
    end
    cd = 0;
  endtask
  initial begin
    act = '{0, 0}; dn = '{0, 0}; p = '{0, 0}; rp = 1'b1;
    cd = 0; req = 0; sp = 0;
    #1;
    test_reset;
    test_request;
    test_sp_gating;
    test_retrigger;
    test_collision;
    test_min_params;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
